// File: rtl/l2_bus_arbiter.sv
// l2_bus_arbiter: two-requester round-robin arbiter in front of the L2 port.
// Requester 0 is the I-side miss handler, requester 1 the D-side miss handler.
// Reads are BURST_LEN-beat bursts and writes are single words.
// Every transaction returns to IDLE for one cycle before the next one starts.
// CNT_W must satisfy 2**CNT_W > BURST_LEN.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | no owner; arbitrate among pending requesters
//   RD_BURST | owner streams read beats until BURST_LEN granted or abort
//   WR       | owner holds a single write until L2 accepts it or abort
module l2_bus_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  output logic [1:0]  rd_granted,
  output logic [1:0]  wr_granted,
  output logic [31:0] l2_addr,
  output logic        l2_rd_en,
  output logic        l2_wr_en,
  output logic [31:0] l2_wr_data,
  input  logic        l2_ready,
  output logic        owner,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR       = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t           state;
  logic             last_owner;
  logic [CNT_W-1:0] beat_cnt;
  logic [1:0]       pending;
  logic             winner;
  logic             sel;

  // Round-robin pick: on contention the requester that did not go last wins.
  always_comb begin
    pending = req_rd | req_wr;
    winner  = (&pending) ? ~last_owner : pending[1];
  end

  // Datapath mux and strobes; IDLE forces requester 0 onto the bus.
  always_comb begin
    sel        = (state != IDLE) & owner;
    l2_addr    = sel ? req_addr1 : req_addr0;
    l2_wr_data = sel ? req_wdata1 : req_wdata0;
    l2_rd_en   = (state == RD_BURST) & req_rd[owner];
    l2_wr_en   = (state == WR) & req_wr[owner];
    busy       = (state != IDLE);
    rd_granted = 2'b00;
    wr_granted = 2'b00;
    if (l2_rd_en & l2_ready) rd_granted[owner] = 1'b1;
    if (l2_wr_en & l2_ready) wr_granted[owner] = 1'b1;
  end

  // Transaction FSM: arbitration, beat counting, completion and abort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            owner <= winner;
            state <= req_wr[winner] ? WR : RD_BURST;
          end
        end
        RD_BURST: begin
          if (!req_rd[owner]) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            last_owner <= owner;
          end else if (l2_ready) begin
            if (beat_cnt == LAST_BEAT) begin
              state      <= IDLE;
              beat_cnt   <= '0;
              last_owner <= owner;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        WR: begin
          // A dropped request and an accepted write both end the transaction.
          if (!req_wr[owner] || l2_ready) begin
            state      <= IDLE;
            last_owner <= owner;
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule
